gray_seq_ctrl: RTL

- Sequencer that sweeps a binary counter between programmable first/last values and emits the Gray-coded value of each step.
- Emits one code per accepted beat on a valid/ready output stream.
- Owns the binary-to-Gray conversion stage, and handles start, stop, direction, wrap-around and loop control.
- Sits between a config/control master and any Gray-code consumer, such as pointer logic or encoder test drivers.

---
 rtl/gray_seq_pkg.sv | 25 ++
 rtl/bin2gray_w.sv | 19 +
 rtl/gray_seq_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/gray_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gray_seq_pkg
//  Description : Shared types and helpers for the Gray-code sequencer:
//                FSM state encoding, default counter width and a
//                single-bit-difference test used by the optional checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package gray_seq_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when the two codes differ in exactly one bit position.
    function automatic logic hamming_is_one(input logic [31:0] a, input logic [31:0] b);
        return ($countones(a ^ b) == 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2gray_w.sv
`default_nettype none
// ============================================================================
//  Module      : bin2gray_w
//  Description : Combinational binary-to-reflected-Gray conversion,
//                gray = bin ^ (bin >> 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2gray_w #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    // Each Gray bit is the XOR of the binary bit and its upper neighbour.
    assign gray = bin ^ (bin >> 1);

endmodule
`default_nettype wire

// File: rtl/gray_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gray_seq_ctrl
//  Description : Sweeps a binary counter from a latched first value to a
//                latched last value (up or down, wrapping modulo 2^WIDTH,
//                optionally looping) and presents each step as a registered
//                binary/Gray pair on a valid/ready stream.
//                Optional macro GRAY_SEQ_CHECK_EN builds a sticky checker that
//                flags delivered codes that are not single-bit steps or whose
//                Gray value does not match the binary count.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_seq_ctrl
    import gray_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] first_val,
    input  logic [WIDTH-1:0] last_val,
    input  logic             dir,
    input  logic             loop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gray,
    output logic [WIDTH-1:0] out_bin,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] gray_q,  gray_d;
    logic [WIDTH-1:0] first_q, first_d;
    logic [WIDTH-1:0] last_q,  last_d;
    logic             dir_q,   dir_d;
    logic             loop_q,  loop_d;
    logic             beat;

    assign out_valid = (state_q == RUN);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign out_bin   = cnt_q;
    assign out_gray  = gray_q;
    assign beat      = out_valid & out_ready;

    // Gray code is derived from the next count so both registers update together.
    bin2gray_w #(.WIDTH(WIDTH)) u_bin2gray (
        .bin  (cnt_d),
        .gray (gray_d)
    );

    // Next-state, counter and sweep-configuration logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        last_d  = last_q;
        dir_d   = dir_q;
        loop_d  = loop_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    first_d = first_val;
                    last_d  = last_val;
                    dir_d   = dir;
                    loop_d  = loop;
                    cnt_d   = first_val;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (beat) begin
                    if (cnt_q != last_q) begin
                        cnt_d = dir_q ? (cnt_q - C_ONE) : (cnt_q + C_ONE);
                    end else if (loop_q) begin
                        cnt_d = first_q;
                    end else begin
                        state_d = DONE;
                    end
                end
                // Abort wins over the final-beat transition; a beat in this cycle still counts.
                if (stop) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gray_q  <= '0;
            first_q <= '0;
            last_q  <= '0;
            dir_q   <= 1'b0;
            loop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gray_q  <= gray_d;
            first_q <= first_d;
            last_q  <= last_d;
            dir_q   <= dir_d;
            loop_q  <= loop_d;
        end
    end

`ifdef GRAY_SEQ_CHECK_EN
    logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
    logic             have_prev_q, have_prev_d;
    logic             err_q,       err_d;

    // Checker: compare each delivered code to the previous one within the sweep.
    always_comb begin
        prev_gray_d = prev_gray_q;
        have_prev_d = have_prev_q;
        err_d       = err_q;
        if ((state_q == IDLE) && start) begin
            have_prev_d = 1'b0;
        end
        if (beat) begin
            if (have_prev_q && !hamming_is_one(32'(prev_gray_q), 32'(gray_q))) begin
                err_d = 1'b1;
            end
            prev_gray_d = gray_q;
            // The step after a loop reload (last -> first) is not a Gray step.
            have_prev_d = !((cnt_q == last_q) && loop_q);
        end
        if (out_valid && (gray_q != (cnt_q ^ (cnt_q >> 1)))) begin
            err_d = 1'b1;
        end
    end

    // Checker registers; err is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_gray_q <= '0;
            have_prev_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            prev_gray_q <= prev_gray_d;
            have_prev_q <= have_prev_d;
            err_q       <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire
